fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: fetch FSM states, fetch-queue entry layout, NOP default.
// Entry carries exc only when FETCH_MISALIGN_CHK_EN is defined.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        exc;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response bus plus decode valid/ready.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_exc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_exc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_exc
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of fetch entries.
// Ports: clk, rst_n, flush, wr_en/wr_data, rd_en/rd_data (head), count.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_en,
  input  fetch_entry_t                   wr_data,
  input  logic                           rd_en,
  output fetch_entry_t                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/REQ/WAIT/DROP fetch FSM feeding a fetch_queue to decode.
// Ports: clk, rst_n, pc_in, pc_hold, flush, bus (fetch_unit_if.master). Option: FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  pc_in,
  output logic         pc_hold,
  input  logic         flush,
  fetch_unit_if.master bus
);

  localparam int         CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   fill;
  logic [CW:0]   fill_nxt;
  logic [31:0]   req_addr;
  logic          outstanding;
  logic          pop;
  logic          granted;
  logic          mis;
  logic          wr_en;
  fetch_entry_t  wr_data;
  fetch_entry_t  head;

  assign outstanding = (state == WAIT);
  assign pop         = bus.dec_valid & bus.dec_ready;
  assign granted     = bus.imem_req & bus.imem_gnt;
  assign fill        = {1'b0, count} + {{CW{1'b0}}, outstanding};
  // occupancy after a WAIT-state write, net of a same-cycle pop
  assign fill_nxt    = {1'b0, count} + (CW + 1)'(1)
                     - {{CW{1'b0}}, pop};

`ifdef FETCH_MISALIGN_CHK_EN
  assign mis = (state == REQ) && (pc_in[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       req_addr <= '0;
    else if (granted) req_addr <= {pc_in[31:2], 2'b00};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!flush && fill < DEPTH_W) state_nxt = REQ;
      end
      REQ: begin
        if (flush)        state_nxt = granted ? DROP : IDLE;
        else if (mis)     state_nxt = IDLE;
        else if (granted) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid)
          state_nxt = (!flush && fill_nxt < DEPTH_W) ? REQ : IDLE;
        else if (flush)
          state_nxt = DROP;
      end
      DROP: begin
        if (bus.imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    unique case (state)
      REQ: begin
        if (!mis) begin
          bus.imem_req  = 1'b1;
          bus.imem_addr = {pc_in[31:2], 2'b00};
        end else if (!flush) begin
          wr_en         = 1'b1;
          wr_data.instr = NOP_INSTR;
          wr_data.pc    = pc_in;
`ifdef FETCH_MISALIGN_CHK_EN
          wr_data.exc   = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (bus.imem_rvalid && !flush) begin
          wr_en         = 1'b1;
          wr_data.instr = bus.imem_rdata;
          wr_data.pc    = req_addr;
        end
      end
      default: ;
    endcase
  end

  // a misaligned slot consumes the PC just like a granted fetch
  assign pc_hold = ~(granted | mis);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign bus.dec_valid = (count != '0);
  assign bus.dec_instr = bus.dec_valid ? head.instr : '0;
  assign bus.dec_pc    = bus.dec_valid ? head.pc : '0;
`ifdef FETCH_MISALIGN_CHK_EN
  assign bus.dec_exc   = bus.dec_valid & head.exc;
`else
  assign bus.dec_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table + scoreboard bench for fetch_unit.
// Drives a PC register and a latency-configurable imem model.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic        hold;
    logic        exc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        flush;

  fetch_unit_if bus ();

  fetch_unit #(
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc_in   (pc_in),
    .pc_hold (pc_hold),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          n_gnt;
  int          n_pop;
  int          lat;
  int          resp_cnt;
  logic [31:0] resp_addr;
  logic [31:0] last_gaddr;
  logic        gnt_en;
  logic        ready;
  logic        drop;
  logic        chk_lat;
  logic        prev_acc;
  logic        s_req, s_hold, s_valid, s_exc, s_gnt;
  logic [31:0] s_addr, s_instr, s_pc;
  exp_t        sb[$];
  vec_t        tbl[5];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5EED_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, sample 2ns later, book-keep after posedge
  task automatic step(input logic fl);
    exp_t e;
    logic rv;
    logic acc;
    flush = fl;
    rv = (resp_cnt == 1);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? memword(resp_addr) : 32'h0;
    bus.dec_ready   = ready;
    bus.imem_gnt    = 1'b0;
    #1;
    s_gnt = gnt_en & bus.imem_req;
    bus.imem_gnt = s_gnt;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_hold  = pc_hold;
    s_valid = bus.dec_valid;
    s_instr = bus.dec_instr;
    s_pc    = bus.dec_pc;
    s_exc   = bus.dec_exc;
    if (chk_lat) chk("dec_valid_latency", 32'(s_valid), 32'(prev_acc));
    if (s_gnt) begin
      n_gnt++;
      last_gaddr = s_addr;
      chk("imem_addr", s_addr, {pc_in[31:2], 2'b00});
      chk("pc_hold_on_gnt", 32'(s_hold), 32'd0);
    end
    if (s_valid && ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", s_pc);
      end else begin
        e = sb.pop_front();
        chk("dec_pc", s_pc, e.pc);
        chk("dec_instr", s_instr, e.instr);
        chk("dec_exc", 32'(s_exc), 32'(e.exc));
      end
    end
    acc = 1'b0;
    if (rv) begin
      if (drop || fl) drop = 1'b0;
      else begin
        sb.push_back('{memword(resp_addr), resp_addr, 1'b0});
        acc = 1'b1;
      end
    end
    if (fl && (resp_cnt > 1 || s_gnt)) drop = 1'b1;
    prev_acc = acc;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    if (resp_cnt > 0) resp_cnt--;
    if (s_gnt) begin
      resp_cnt  = lat;
      resp_addr = {pc_in[31:2], 2'b00};
    end
    if (!s_hold) pc_in = pc_in + 32'd4;
    @(negedge clk);
  endtask

  task automatic until_gnt(input int n, input string name);
    int k;
    k = 0;
    while (n_gnt < n && k < 30) begin
      step(1'b0);
      k++;
    end
    chk(name, 32'(n_gnt >= n), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
    chk({tag, "_dec_exc"}, 32'(bus.dec_exc), 32'd0);
    chk({tag, "_pc_hold"}, 32'(pc_hold), 32'd1);
    chk({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
    chk({tag, "_dec_instr"}, bus.dec_instr, 32'd0);
    chk({tag, "_dec_pc"}, bus.dec_pc, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    n_chk = 0; n_fail = 0; n_gnt = 0; n_pop = 0;
    lat = 1; resp_cnt = 0; resp_addr = '0; last_gaddr = '0;
    gnt_en = 1'b0; ready = 1'b1; drop = 1'b0;
    chk_lat = 1'b0; prev_acc = 1'b0;
    rst_n = 1'b0; flush = 1'b0; pc_in = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0; bus.dec_ready = 1'b0;

    tbl[0] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_0008, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
`ifdef FETCH_MISALIGN_CHK_EN
    tbl[2] = '{32'h0000_0006, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_1003, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
`else
    tbl[2] = '{32'h0000_0006, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_1003, 1'b1, 32'h0000_1000, 1'b1, 1'b0};
`endif
    tbl[4] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // address/alignment vectors
    for (int i = 0; i < 5; i++) begin
      pc_in = tbl[i].pc;
      gnt_en = 1'b0;
      step(1'b1);
      step(1'b0);
      if (tbl[i].exc) sb.push_back('{NOP, tbl[i].pc, 1'b1});
      step(1'b0);
      chk("vec_req", 32'(s_req), 32'(tbl[i].req));
      chk("vec_addr", s_addr, tbl[i].addr);
      chk("vec_pc_hold", 32'(s_hold), 32'(tbl[i].hold));
      step(1'b0);
      chk("vec_req_held", 32'(s_req), 32'(tbl[i].req));
      chk("vec_addr_held", s_addr, tbl[i].addr);
      if (tbl[i].req) begin
        gnt_en = 1'b1;
        step(1'b0);
        gnt_en = 1'b0;
        step(1'b0);
        step(1'b0);
      end
      chk("vec_drained", 32'(sb.size()), 32'd0);
    end

    // back-to-back stream 0x0, 0x4, 0x8
    step(1'b1);
    pc_in = 32'h0; lat = 1; ready = 1'b1;
    gnt_en = 1'b1; n_gnt = 0; p0 = n_pop; chk_lat = 1'b1;
    for (int k = 0; k < 30 && n_pop - p0 < 3; k++) begin
      if (n_gnt >= 3) gnt_en = 1'b0;
      step(1'b0);
    end
    chk_lat = 1'b0;
    gnt_en = 1'b0;
    chk("stream_pops", 32'(n_pop - p0), 32'd3);

    // backpressure fills exactly DEPTH entries
    step(1'b1);
    pc_in = 32'h40; ready = 1'b0; gnt_en = 1'b1; n_gnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      if (k >= 6) begin
        chk("bp_imem_req", 32'(s_req), 32'd0);
        chk("bp_pc_hold", 32'(s_hold), 32'd1);
        chk("bp_dec_valid", 32'(s_valid), 32'd1);
      end
    end
    chk("bp_grants", 32'(n_gnt), 32'd2);
    chk("bp_entries", 32'(sb.size()), 32'd2);
    ready = 1'b1; gnt_en = 1'b0;
    step(1'b0);
    chk("bp_hold_at_pop", 32'(s_hold), 32'd1);
    repeat (3) step(1'b0);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // flush while WAIT; response lands 3 cycles later
    step(1'b1);
    pc_in = 32'h200; lat = 4; gnt_en = 1'b1; n_gnt = 0;
    until_gnt(1, "fw_gnt_budget");
    gnt_en = 1'b0;
    step(1'b1);
    pc_in = 32'h100;
    repeat (3) begin
      step(1'b0);
      chk("fw_dec_valid", 32'(s_valid), 32'd0);
      chk("fw_no_req", 32'(s_req), 32'd0);
    end
    lat = 1; gnt_en = 1'b1; n_gnt = 0; p0 = n_pop;
    until_gnt(1, "fw_regnt_budget");
    chk("fw_new_addr", last_gaddr, 32'h100);
    gnt_en = 1'b0;
    repeat (3) step(1'b0);
    chk("fw_popped", 32'(n_pop - p0), 32'd1);

    // flush coincident with rvalid while queue holds one entry
    step(1'b1);
    pc_in = 32'h300; ready = 1'b0; gnt_en = 1'b1; n_gnt = 0;
    until_gnt(2, "fr_gnt_budget");
    gnt_en = 1'b0;
    step(1'b1);
    pc_in = 32'h340;
    step(1'b0);
    chk("fr_empty", 32'(s_valid), 32'd0);

    // pop and write in the same cycle keep count
    gnt_en = 1'b1; n_gnt = 0;
    until_gnt(2, "pw_gnt_budget");
    gnt_en = 1'b0; ready = 1'b1;
    step(1'b0);
    chk("pw_valid_before", 32'(s_valid), 32'd1);
    step(1'b0);
    chk("pw_count_kept", 32'(s_valid), 32'd1);
    step(1'b0);
    chk("pw_empty_after", 32'(s_valid), 32'd0);
    chk("pw_drained", 32'(sb.size()), 32'd0);

    // async reset mid-WAIT with a queued entry
    step(1'b1);
    pc_in = 32'h500; ready = 1'b0; lat = 1; gnt_en = 1'b1; n_gnt = 0;
    for (int k = 0; k < 30 && n_gnt < 2; k++) begin
      if (n_gnt == 1) lat = 3;
      step(1'b0);
    end
    chk("rst_gnt_budget", 32'(n_gnt), 32'd2);
    gnt_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    resp_cnt = 0; drop = 1'b0; sb.delete();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pc_in = 32'h600; lat = 1; ready = 1'b1; gnt_en = 1'b1; n_gnt = 0;
    p0 = n_pop;
    until_gnt(1, "rst_regnt_budget");
    chk("rst_restart_addr", last_gaddr, 32'h600);
    gnt_en = 1'b0;
    repeat (3) step(1'b0);
    chk("rst_restart_pop", 32'(n_pop - p0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
